// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry front end.
//   entry_state_t : 2-bit FSM state encoding, also shown on the LEDs.
//   MODE_W        : width of the captured ALU mode field.
//   DEBOUNCE_DEFAULT : stable cycles required before a button change is
//                      accepted (10 ms at 100 MHz).
package operand_entry_pkg;

  localparam int MODE_W           = 2;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_MODE  = 2'd2,
    S_VALID = 2'd3
  } entry_state_t;

endpackage

// File: rtl/operand_entry_button.sv
// button_debounce: synchronizes one raw push button, debounces it and
// produces a single-cycle pulse on each accepted press.
//   clock_100Mhz : system clock, rising edge
//   reset        : synchronous, active-low
//   btn_raw      : asynchronous button input
//   btn_level    : debounced button level
//   btn_pulse    : one-cycle high on a 0->1 change of btn_level
module button_debounce
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_prev_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      stable_reg      <= 1'b0;
      stable_prev_reg <= 1'b0;
      pulse_reg       <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      sync1_reg       <= btn_raw;
      sync2_reg       <= sync1_reg;
      stable_prev_reg <= stable_reg;
      // Pulse is registered from the stable edge, so a clean raw change
      // shows up as a pulse DEBOUNCE_CYCLES+3 edges later.
      pulse_reg       <= stable_reg & ~stable_prev_reg;
      if (sync2_reg != stable_reg) begin
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end else begin
        // Any agreeing cycle restarts the count: short glitches are dropped.
        cnt_reg <= '0;
      end
    end
  end

  assign btn_level = stable_reg;
  assign btn_pulse = pulse_reg;

endmodule

// File: rtl/operand_entry.sv
// operand_entry: input sequencer for the ALU datapath. The user enters A,
// then B, then the mode with the slide switches and the next/back buttons;
// the completed set is offered to alu_core with op_valid/alu_ready.
//   clock_100Mhz : system clock, rising edge
//   reset        : synchronous, active-low
//   sw           : raw slide switches (operand; sw[1:0] is the mode)
//   btn_next     : raw button, capture current field and advance
//   btn_back     : raw button, step back one field
//   alu_ready    : consumer accepts the operand set
//   A, B, mode   : captured operand set (registered)
//   op_valid     : operand set complete and stable
//   entry_state  : current FSM state for LED indication
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int DATA_W          = 5
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_next,
  input  logic              btn_back,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [MODE_W-1:0] mode,
  output logic              op_valid,
  output logic [1:0]        entry_state
);

  logic [DATA_W-1:0] sw_sync1_reg, sw_sync2_reg;
  logic              next_pulse, back_pulse;
  logic              next_level, back_level;

  entry_state_t      state_reg, state_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [MODE_W-1:0] mode_reg, mode_next;
  logic              valid_reg, valid_next;
  logic              next_ev, back_ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_next),
    .btn_level    (next_level),
    .btn_pulse    (next_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_back),
    .btn_level    (back_level),
    .btn_pulse    (back_pulse)
  );

  // Conflicting next+back in one cycle cancel each other.
  assign next_ev = next_pulse & ~back_pulse;
  assign back_ev = back_pulse & ~next_pulse;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
      state_reg    <= S_A;
      a_reg        <= '0;
      b_reg        <= '0;
      mode_reg     <= '0;
      valid_reg    <= 1'b0;
    end else begin
      sw_sync1_reg <= sw;
      sw_sync2_reg <= sw_sync1_reg;
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      mode_reg     <= mode_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    mode_next  = mode_reg;
    valid_next = valid_reg;
    case (state_reg)
      S_A: begin
        if (next_ev) begin
          a_next     = sw_sync2_reg;
          state_next = S_B;
        end
      end
      S_B: begin
        if (next_ev) begin
          b_next     = sw_sync2_reg;
          state_next = S_MODE;
        end else if (back_ev) begin
          state_next = S_A;
        end
      end
      S_MODE: begin
        if (next_ev) begin
          mode_next  = sw_sync2_reg[MODE_W-1:0];
          valid_next = 1'b1;
          state_next = S_VALID;
        end else if (back_ev) begin
          state_next = S_B;
        end
      end
      S_VALID: begin
        // Handshake takes priority over a coincident back press.
        if (alu_ready) begin
          valid_next = 1'b0;
          state_next = S_A;
        end else if (back_ev) begin
          valid_next = 1'b0;
          state_next = S_MODE;
        end
      end
      default: state_next = S_A;
    endcase
  end

  assign A           = a_reg;
  assign B           = b_reg;
  assign mode        = mode_reg;
  assign op_valid    = valid_reg;
  assign entry_state = state_reg;

endmodule

// File: tb/tb_operand_entry.sv
// Directed testbench for operand_entry with DEBOUNCE_CYCLES=4.
module tb_operand_entry;

  localparam int N      = 4;
  localparam int DATA_W = 5;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] sw;
  logic              btn_next;
  logic              btn_back;
  logic              alu_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [1:0]        mode;
  logic              op_valid;
  logic [1:0]        entry_state;

  int passed = 0;
  int total  = 0;

  operand_entry #(.DEBOUNCE_CYCLES(N), .DATA_W(DATA_W)) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .sw           (sw),
    .btn_next     (btn_next),
    .btn_back     (btn_back),
    .alu_ready    (alu_ready),
    .A            (A),
    .B            (B),
    .mode         (mode),
    .op_valid     (op_valid),
    .entry_state  (entry_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Clean press: after it returns the press has been acted on and the
  // button is released and debounced low again.
  task automatic press_next();
    btn_next = 1'b1;
    tick(N + 4);
    btn_next = 1'b0;
    tick(N + 4);
  endtask

  task automatic press_back();
    btn_back = 1'b1;
    tick(N + 4);
    btn_back = 1'b0;
    tick(N + 4);
  endtask

  initial begin
    reset = 1'b0; sw = '0; btn_next = 1'b0; btn_back = 1'b0; alu_ready = 1'b0;
    tick(2);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_mode", mode, 0);
    check("rst_valid", op_valid, 0);
    check("rst_state", entry_state, 0);
    reset = 1'b1;
    tick(1);

    // Full entry
    sw = 5'd13; press_next();
    check("entry_A", A, 13);
    check("entry_stB", entry_state, 1);
    sw = 5'd7; press_next();
    check("entry_B", B, 7);
    check("entry_stM", entry_state, 2);
    sw = 5'b00010; press_next();
    check("entry_mode", mode, 2);
    check("entry_valid", op_valid, 1);
    check("entry_stV", entry_state, 3);
    $display("full entry: A=%0d B=%0d mode=%0d valid=%0d", A, B, mode, op_valid);

    // next is ignored in S_VALID
    sw = 5'd20; press_next();
    check("vnext_state", entry_state, 3);
    check("vnext_A", A, 13);
    check("vnext_B", B, 7);

    // Hold stability while switches sweep
    for (int v = 0; v < 32; v++) begin
      sw = v[DATA_W-1:0];
      tick(1);
    end
    check("hold_A", A, 13);
    check("hold_B", B, 7);
    check("hold_mode", mode, 2);
    check("hold_valid", op_valid, 1);

    // Handshake
    alu_ready = 1'b1; tick(1); alu_ready = 1'b0;
    check("hs_valid", op_valid, 0);
    check("hs_state", entry_state, 0);
    check("hs_A", A, 13);
    check("hs_B", B, 7);
    check("hs_mode", mode, 2);
    $display("handshake: state=%0d valid=%0d", entry_state, op_valid);

    // Debounce: 3-cycle pulse rejected
    sw = 5'd9;
    btn_next = 1'b1; tick(3); btn_next = 1'b0; tick(10);
    check("short_state", entry_state, 0);
    check("short_A", A, 13);

    // Bounce 1,0 then steady high: pulse N+3 edges after the last rise
    btn_next = 1'b1; tick(1);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1;
    tick(N + 2);
    check("bounce_nopulse", dut.u_next_db.btn_pulse, 0);
    check("bounce_state0", entry_state, 0);
    tick(1);
    check("bounce_pulse", dut.u_next_db.btn_pulse, 1);
    check("bounce_state1", entry_state, 0);
    tick(1);
    check("bounce_pulse_end", dut.u_next_db.btn_pulse, 0);
    check("bounce_state2", entry_state, 1);
    check("bounce_A", A, 9);
    btn_next = 1'b0; tick(N + 4);
    $display("debounce: A=%0d state=%0d", A, entry_state);

    // Back navigation
    sw = 5'd4; press_next();
    check("nav_stM", entry_state, 2);
    press_back();
    check("nav_back1", entry_state, 1);
    press_back();
    check("nav_back0", entry_state, 0);
    check("nav_A", A, 9);
    press_back();
    check("nav_backA", entry_state, 0);
    sw = 5'd11; press_next(); press_next();
    sw = 5'd1; press_next();
    check("nav_stV", entry_state, 3);
    check("nav_mode", mode, 1);
    press_back();
    check("vback_state", entry_state, 2);
    check("vback_valid", op_valid, 0);
    $display("back nav: state=%0d valid=%0d", entry_state, op_valid);

    // Simultaneous next+back in S_MODE
    btn_next = 1'b1; btn_back = 1'b1;
    tick(N + 4);
    btn_next = 1'b0; btn_back = 1'b0;
    tick(N + 4);
    check("simul_state", entry_state, 2);
    check("simul_valid", op_valid, 0);
    press_next();
    check("simul_stV", entry_state, 3);

    // Back pulse coincident with alu_ready in S_VALID: handshake wins
    btn_back = 1'b1;
    tick(N + 3);
    check("coinc_pulse", dut.u_back_db.btn_pulse, 1);
    alu_ready = 1'b1; tick(1); alu_ready = 1'b0;
    check("coinc_state", entry_state, 0);
    check("coinc_valid", op_valid, 0);
    btn_back = 1'b0; tick(N + 4);
    check("coinc_after", entry_state, 0);
    $display("coincident: state=%0d valid=%0d", entry_state, op_valid);

    // Reset mid-operation
    sw = 5'd13; press_next(); press_next();
    sw = 5'd3; press_next();
    check("mid_state", entry_state, 3);
    check("mid_A", A, 13);
    #2 reset = 1'b0;
    #3;
    check("mid_noedge_A", A, 13);
    check("mid_noedge_state", entry_state, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_A", A, 0);
    check("mid_rst_B", B, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_valid", op_valid, 0);
    check("mid_rst_state", entry_state, 0);
    $display("reset mid-op: A=%0d state=%0d", A, entry_state);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Front-end input sequencer for the ALU datapath; the input-side counterpart to the display output path.
- Synchronizes the slide switches, and synchronizes and debounces two push buttons.
- Walks the user through entering A, then B, then mode.
- Presents the captured operand set to alu_core with a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button change is accepted (10 ms at 100 MHz; benches use 4).
- DATA_W, 5, operand width of A and B.

Ports:
- clock_100Mhz  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- sw  input  DATA_W  raw slide switches. Operand value; sw[1:0] also gives the mode value.
- btn_next  input  1  raw push button: capture the current field and advance.
- btn_back  input  1  raw push button: step back one field.
- alu_ready  input  1  consumer accepts the operand set.
- A  output  DATA_W  captured operand A.
- B  output  DATA_W  captured operand B.
- mode  output  2  captured ALU mode.
- op_valid  output  1  operand set is complete and stable.
- entry_state  output  2  current FSM state, for LED indication.

Behaviour:
- Reset (reset==0 at a clock edge):
  - A=0, B=0, mode=0, op_valid=0, entry_state=S_A.
  - All synchronizer flops, debounced levels and counters cleared to 0.
  - Reset mid-entry discards any partial entry.
- Input synchronization:
  - sw, btn_next and btn_back each pass through a 2-flop synchronizer.
  - sw is not debounced; captures use the synchronized sw.
- Debounce (per button):
  - While the synchronized level differs from the stable level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
  - Any cycle of agreement clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press pulse:
  - One cycle high on a 0->1 transition of the stable level.
  - For a raw input held stable, the pulse occurs exactly DEBOUNCE_CYCLES+3 rising edges after the raw change.
  - Releases generate no pulse.
- FSM states, encoded on entry_state:
  - S_A=0:
    - next -> A<=sw, go to S_B.
    - back ignored.
  - S_B=1:
    - next -> B<=sw, go to S_MODE.
    - back -> S_A, A retained.
  - S_MODE=2:
    - next -> mode<=sw[1:0], go to S_VALID, op_valid<=1 on the same edge.
    - back -> S_B.
  - S_VALID=3:
    - op_valid=1; A, B and mode are frozen.
    - alu_ready==1 -> handshake completes: op_valid<=0 and state<=S_A on that edge.
    - back with alu_ready==0 -> op_valid<=0, go to S_MODE.
    - next ignored.
- Simultaneous events:
  - next and back pulses in the same cycle: both ignored, state unchanged.
  - alu_ready and back in the same cycle in S_VALID: the handshake wins.
- alu_ready outside S_VALID is ignored.
- A, B and mode are registered outputs; they change only on a capture edge or on reset, never combinationally from sw.
- Latency:
  - From next-pulse to captured value visible: 1 cycle.
  - From handshake to op_valid low: 1 cycle.

Decomposition:
- Shared package:
  - State encoding constants S_A/S_B/S_MODE/S_VALID (2-bit).
  - MODE_W=2.
  - Default DEBOUNCE_CYCLES.
- Sub-module button_debounce, instantiated twice:
  - Contains the 2-flop synchronizer, the counter sized $clog2(DEBOUNCE_CYCLES)+1, and the rising-edge pulse generator.
  - Ports: clock_100Mhz, reset, btn_raw, btn_level, btn_pulse.
- Top level holds the sw synchronizer, the FSM and the output registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Full entry:
  - Stimulus: sw=5'd13, press next; sw=5'd7, press next; sw=5'b00010, press next.
  - Response: A=13, B=7, mode=2, op_valid=1, entry_state=3.
  - Hold alu_ready=1 for one cycle -> op_valid=0 and entry_state=0 on the next edge; A, B and mode unchanged.
- Debounce:
  - Stimulus: btn_next high for 3 cycles then low; then a bounce pattern 1,0,1,1 followed by a steady high.
  - Response: no state change for the short pulse or the bounce; exactly one pulse, DEBOUNCE_CYCLES+3 edges after the last raw transition of the steady high.
- Back navigation:
  - Stimulus: in S_MODE press back, then back again.
  - Response: entry_state 2->1->0; A retained.
  - In S_VALID with alu_ready=0, press back -> op_valid=0, entry_state=2.
- Simultaneous events:
  - Stimulus: next and back raw edges aligned, both held.
  - Response: state unchanged.
  - In S_VALID, back pulse coincident with alu_ready=1 -> entry_state=0 and op_valid=0.
- Reset mid-operation:
  - Stimulus: in S_VALID with A=13, drive reset=0 for one cycle.
  - Response: A=B=mode=0, op_valid=0, entry_state=0.
  - Reset asserted between clock edges has no effect until the next edge.
- Hold stability:
  - Stimulus: in S_VALID, toggle sw through 0..31.
  - Response: A, B and mode are constant and op_valid stays 1.
